// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration between the ALU (req0)
// and the load unit (req1), plus an init sweep that writes INIT_VALUE to every
// register. All regfile write signals are registered (one-cycle write latency).
//
// state   | meaning
// --------+-----------------------------------------------
// ST_ARB  | normal arbitration between the two requesters
// ST_INIT | init sweep in progress, requesters stalled
module regfile_wb_arbiter #(
   parameter int AW = 6,
   parameter int DW = 32,
   parameter int NREGS = 64,
   parameter logic [DW-1:0] INIT_VALUE = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   output logic          busy,
   output logic          init_done,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd
);

   typedef enum logic {ST_ARB, ST_INIT} state_t;

   // One extra counter bit so NREGS == 2**AW reaches its last value without wrapping.
   localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

   state_t      state;
   logic        prio;
   logic [AW:0] cnt;
   logic        arb_open;
   logic        grant0;
   logic        grant1;

   // Grant decode: a lone requester always wins, prio breaks ties; init blocks all grants.
   assign arb_open   = (state == ST_ARB) & ~init;
   assign grant0     = req0_valid & (~req1_valid | ~prio);
   assign grant1     = req1_valid & (~req0_valid | prio);
   assign req0_ready = arb_open & grant0;
   assign req1_ready = arb_open & grant1;
   assign busy       = (state == ST_INIT);

   // Sequencer, priority pointer and registered regfile write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_ARB;
         prio      <= 1'b0;
         cnt       <= '0;
         rf_we     <= 1'b0;
         rf_wa     <= '0;
         rf_wd     <= '0;
         init_done <= 1'b0;
      end else begin
         rf_we     <= 1'b0;
         init_done <= 1'b0;
         case (state)
            ST_ARB: begin
               if (init) begin
                  state <= ST_INIT;
                  cnt   <= '0;
               end else if (req0_ready) begin
                  rf_we <= 1'b1;
                  rf_wa <= req0_addr;
                  rf_wd <= req0_data;
                  prio  <= 1'b1;
               end else if (req1_ready) begin
                  rf_we <= 1'b1;
                  rf_wa <= req1_addr;
                  rf_wd <= req1_data;
                  prio  <= 1'b0;
               end
            end
            ST_INIT: begin
               rf_we <= 1'b1;
               rf_wa <= cnt[AW-1:0];
               rf_wd <= INIT_VALUE;
               cnt   <= cnt + 1'b1;
               // The final write lands in the first ARB cycle, so pending requests
               // are granted there with no gap and no port conflict.
               if (cnt == CNT_LAST) begin
                  state     <= ST_ARB;
                  init_done <= 1'b1;
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with default parameters.
module tb_regfile_wb_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NREGS = 64;

   logic          clk;
   logic          reset;
   logic          init;
   logic          busy;
   logic          init_done;
   logic          req0_valid;
   logic          req0_ready;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req1_valid;
   logic          req1_ready;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;

   int checks = 0;
   int failures = 0;

   regfile_wb_arbiter #(.AW(AW), .DW(DW), .NREGS(NREGS), .INIT_VALUE('0)) dut (
      .clk(clk), .reset(reset), .init(init), .busy(busy), .init_done(init_done),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
      checks++; if (rf_wa !== '0) begin failures++; $display("FAIL reset_rf_wa got=%0d exp=0", rf_wa); end
      checks++; if (rf_wd !== '0) begin failures++; $display("FAIL reset_rf_wd got=%0h exp=0", rf_wd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 32'd7;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 6'd5, 32'd7}) begin
         failures++; $display("FAIL single_write got we=%0b wa=%0d wd=%0h exp we=1 wa=5 wd=7", rf_we, rf_wa, rf_wd); end
      tick();
      checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b0, 6'd5, 32'd7}) begin
         failures++; $display("FAIL single_idle got we=%0b wa=%0d wd=%0h exp we=0 wa=5 wd=7", rf_we, rf_wa, rf_wd); end
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 32'hA;
      req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 32'hB;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL contention_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         tick();
         checks++; if ({rf_we, rf_wa, rf_wd} !== ((i % 2 == 0) ? {1'b1, 6'd1, 32'hA} : {1'b1, 6'd2, 32'hB})) begin
            failures++; $display("FAIL contention_write%0d got we=%0b wa=%0d wd=%0h", i, rf_we, rf_wa, rf_wd); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_prio_update();
      // Lone req0 grant moves prio to req1; lone req1 grant must move it back.
      req0_valid = 1'b1; req0_addr = 6'd11; req0_data = 32'h11;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 6'd12; req1_data = 32'h12;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL lone1_ready got=%b exp=01", {req0_ready, req1_ready}); end
      tick();
      checks++; if ({rf_we, rf_wa} !== {1'b1, 6'd12}) begin failures++; $display("FAIL lone1_write got we=%0b wa=%0d exp we=1 wa=12", rf_we, rf_wa); end
      req0_valid = 1'b1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL prio_after_lone got=%b exp=10", {req0_ready, req1_ready}); end
      tick();
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL prio_alternate got=%b exp=01", {req0_ready, req1_ready}); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      req0_valid = 1'b1; req0_addr = 6'd4; req0_data = 32'h1;
      tick();
      req0_data = 32'h2;
      checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 6'd4, 32'h1}) begin failures++; $display("FAIL b2b_first got we=%0b wa=%0d wd=%0h exp 1/4/1", rf_we, rf_wa, rf_wd); end
      tick();
      req0_valid = 1'b0;
      checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 6'd4, 32'h2}) begin failures++; $display("FAIL b2b_second got we=%0b wa=%0d wd=%0h exp 1/4/2", rf_we, rf_wa, rf_wd); end
      tick();
   endtask

   task automatic test_init_pending();
      int bad = 0;
      do_reset();
      req0_valid = 1'b1; req0_addr = 6'd3; req0_data = 32'd9;
      init = 1'b1;
      #1;
      checks++; if ({req0_ready, busy} !== 2'b00) begin failures++; $display("FAIL init_cycle got ready=%0b busy=%0b exp 0/0", req0_ready, busy); end
      tick();
      init = 1'b0;
      #1;
      for (int c = 0; c < NREGS; c++) begin
         if (req0_ready !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) bad++;
         if (c == 0 && rf_we !== 1'b0) bad++;
         if (c > 0 && (rf_we !== 1'b1 || rf_wa !== AW'(c - 1) || rf_wd !== '0)) bad++;
         tick();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL sweep_cycles got bad=%0d exp=0", bad); end
      checks++; if ({rf_we, rf_wa, rf_wd, init_done} !== {1'b1, 6'd63, 32'd0, 1'b1}) begin
         failures++; $display("FAIL sweep_last got we=%0b wa=%0d wd=%0h done=%0b exp 1/63/0/1", rf_we, rf_wa, rf_wd, init_done); end
      checks++; if ({req0_ready, busy} !== 2'b10) begin failures++; $display("FAIL sweep_release got ready=%0b busy=%0b exp 1/0", req0_ready, busy); end
      tick();
      req0_valid = 1'b0;
      checks++; if ({rf_we, rf_wa, rf_wd, init_done} !== {1'b1, 6'd3, 32'd9, 1'b0}) begin
         failures++; $display("FAIL pending_served got we=%0b wa=%0d wd=%0h done=%0b exp 1/3/9/0", rf_we, rf_wa, rf_wd, init_done); end
      tick();
   endtask

   task automatic test_reset_mid_sweep();
      int pulses = 0;
      int wrs = 0;
      init = 1'b1;
      tick();
      init = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({busy, rf_we, init_done} !== 3'b000) begin
         failures++; $display("FAIL midreset got busy=%0b we=%0b done=%0b exp 0/0/0", busy, rf_we, init_done); end
      for (int i = 0; i < 60; i++) begin
         if (init_done) pulses++;
         if (rf_we) wrs++;
         tick();
      end
      checks++; if (pulses != 0 || wrs != 0) begin failures++; $display("FAIL midreset_quiet got pulses=%0d writes=%0d exp 0/0", pulses, wrs); end
      req0_valid = 1'b1; req0_addr = 6'd9; req0_data = 32'h55;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%0b exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 6'd9, 32'h55}) begin
         failures++; $display("FAIL midreset_write got we=%0b wa=%0d wd=%0h exp 1/9/55", rf_we, rf_wa, rf_wd); end
      tick();
   endtask

   task automatic test_init_during_init();
      int pulses = 0;
      int wrs = 0;
      int bad = 0;
      int exp_a = 0;
      int done_wa = -1;
      init = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         init = (i == 10);
         if (rf_we) begin
            if (rf_wa !== AW'(exp_a)) bad++;
            exp_a++;
            wrs++;
         end
         if (init_done) begin
            pulses++;
            done_wa = int'(rf_wa);
         end
         tick();
      end
      init = 1'b0;
      checks++; if (wrs != NREGS || bad != 0) begin failures++; $display("FAIL reinit_writes got writes=%0d bad=%0d exp %0d/0", wrs, bad, NREGS); end
      checks++; if (pulses != 1) begin failures++; $display("FAIL reinit_pulses got=%0d exp=1", pulses); end
      checks++; if (done_wa != NREGS - 1) begin failures++; $display("FAIL reinit_done_addr got=%0d exp=%0d", done_wa, NREGS - 1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reinit_end_busy got=%0b exp=0", busy); end
   endtask

   initial begin
      reset = 1'b1; init = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      test_reset();
      test_single();
      test_contention();
      test_prio_update();
      test_back_to_back();
      test_init_pending();
      test_reset_mid_sweep();
      test_init_during_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port (we/wa/wd) and shares it between two writeback sources: requester 0 (ALU) and requester 1 (load unit).
- Round-robin arbitration with a valid/ready handshake per requester.
- An init sequencer sweeps every register to a fixed value on command.
- Sits between the CPU writeback stage and the regfile write inputs; all regfile write signals are registered.

Parameters:
- AW, 6, register address width.
- DW, 32, data width.
- NREGS, 64, number of registers swept by init (1..2^AW).
- INIT_VALUE, 0, value written to every register during init.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  request a full register sweep; sampled only in ARB.
- busy  out  1  high while the init sweep is in progress.
- init_done  out  1  one-cycle pulse on the final init write.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 write accepted this cycle.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  DW  requester 1 write data.
- rf_we  out  1  regfile write enable (registered).
- rf_wa  out  AW  regfile write address (registered).
- rf_wd  out  DW  regfile write data (registered).

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: state=ARB, prio=0 (requester 0 preferred), cnt=0, rf_we=0, rf_wa=0, rf_wd=0, init_done=0, busy=0.
- Reset applies on any cycle, including mid-sweep: the sweep aborts with no init_done, and rf_we=0 the next cycle.
- States:
  - ARB: normal arbitration.
  - INIT: sweep in progress.
- ARB, init=1:
  - No ready is asserted that cycle; init wins over pending requests.
  - Next state INIT, cnt=0.
  - rf_we=0 next cycle.
- ARB, init=0:
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by prio.
  - req_k_ready is combinational: (state==ARB) & ~init & grant_k.
  - After any grant, prio points to the non-granted requester. Under continuous contention, grants strictly alternate.
- Write latency: a grant in cycle N produces rf_we=1 with the granted addr/data in cycle N+1 (one-cycle latency).
  - With no grant, rf_we=0 next cycle and rf_wa/rf_wd hold their last value.
- Handshake:
  - A requester holds valid, addr and data stable until ready.
  - valid must not depend on ready.
  - Throughput is one write per cycle total.
- INIT:
  - busy = (state==INIT), combinationally decoded from the state register.
  - Each INIT cycle with counter value c produces rf_we=1, rf_wa=c, rf_wd=INIT_VALUE in the next cycle; cnt increments by 1.
  - When c==NREGS-1: the next state is ARB, and the final write's cycle has init_done=1.
  - INIT lasts exactly NREGS cycles and produces NREGS consecutive writes to addresses 0..NREGS-1.
- During INIT:
  - Both readys are 0.
  - init is ignored (no restart).
  - Requests stay pending and are served from the first ARB cycle.
  - That first ARB cycle coincides with the init_done write, so there is no gap and no port conflict.
- Ordering:
  - No merging or reordering of writes.
  - Back-to-back writes to the same address are issued in grant order; the later write wins.
- cnt is AW+1 bits wide, so NREGS=2^AW does not wrap.

Test Plan:
- Single requester:
  - Stimulus: after reset, req0_valid=1, addr=5, data=7 for 1 cycle.
  - Required: req0_ready=1 that cycle; next cycle rf_we=1, rf_wa=5, rf_wd=7; following cycle rf_we=0.
- Contention fairness:
  - Stimulus: both valid for 4 cycles, req0 (addr=1, data=0xA), req1 (addr=2, data=0xB).
  - Required: grants 0,1,0,1; rf_wa sequence 1,2,1,2 one cycle later.
- Priority update from a lone grant:
  - Stimulus: req1 alone is granted once, then both assert valid.
  - Required: requester 0 is granted first.
- Init sweep with pending request:
  - Stimulus: init=1 for one cycle with req0_valid=1 (addr=3, data=9) held.
  - Required: req0_ready=0 for NREGS+1 cycles; rf_wa steps 0..63 with rf_wd=0; init_done=1 only with rf_wa=63; req0_ready=1 in that same cycle; next cycle rf_wa=3, rf_wd=9.
- Reset mid-sweep:
  - Stimulus: reset=1 at cnt=20.
  - Required: next cycle busy=0, rf_we=0; no init_done; a subsequent req0 write is served normally.
- init during INIT:
  - Stimulus: assert init again at cnt=10.
  - Required: the sweep continues unchanged to address 63; exactly one init_done pulse.
